// File: rtl/four_12_12_st1_mem_reader_pkg.sv
// Shared types for the st1 data-memory reader: memory request struct, reader FSM
// states and the fixed geometry of the 32x512 data memory.
package four_12_12_st1_mem_reader_pkg;

    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int DEPTH = 2;

    localparam logic [AW:0] CNT_ONE = 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          rd_en;
        logic          wr_en;
    } data_int_32_9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    // Word address after a<n>; the 512-entry memory wraps 511 -> 0.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return a + {{(AW-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/four_12_12_st1_mem_reader_if.sv
// Valid/ready word stream with a last flag; the reader is the master side.
interface four_12_12_st1_mem_reader_if;
    import four_12_12_st1_mem_reader_pkg::*;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);

endinterface

// File: rtl/four_12_12_st1_mem_reader_skid.sv
// Two-entry FIFO of {data, last}; absorbs the read in flight when the sink stalls.
module four_12_12_st1_mem_reader_skid
    import four_12_12_st1_mem_reader_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          push_last,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          head_last,
    output logic [1:0]    count
);

    logic [DW-1:0] data_q [DEPTH];
    logic          last_q [DEPTH];
    logic          wr_ptr;
    logic          rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                last_q[i] <= 1'b0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= push_data;
                last_q[wr_ptr] <= push_last;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = data_q[rd_ptr];
    assign head_last = last_q[rd_ptr];

endmodule

// File: rtl/four_12_12_st1_mem_reader.sv
// Block reader for the st1 data memory: issues consecutive reads from base_addr and
// streams the returned words out with backpressure, a last flag and a done pulse.
module four_12_12_st1_mem_reader
    import four_12_12_st1_mem_reader_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [AW-1:0]                     base_addr,
    input  logic [AW:0]                       length,
    output logic                              busy,
    output logic                              done,
    output data_int_32_9                      data_int,
    input  logic [DW-1:0]                     data_int_rd_data,
    four_12_12_st1_mem_reader_if.master       st
);

    rd_state_e     state;
    logic [AW-1:0] cur_addr;
    logic [AW:0]   len_q;
    logic [AW:0]   issue_cnt;
    logic [AW:0]   acc_cnt;

    logic          vld_p0;
    logic          last_p0;
    logic          vld_p1;
    logic          last_p1;

    logic [1:0]    buf_count;
    logic          pop;
    logic [2:0]    occ;
    logic          last_beat;

    assign pop = st.out_valid & st.out_ready;

    // Buffer occupancy after this edge, counting the word now on rd_data; a new
    // read is only issued if its data is guaranteed a slot next cycle.
    assign occ     = {1'b0, buf_count} + {2'b00, vld_p1} - {2'b00, pop};
    assign vld_p0  = (state == ST_RUN) && (occ < 3'(DEPTH));
    assign last_p0 = (issue_cnt == len_q - CNT_ONE);

    assign last_beat = pop && (acc_cnt == len_q - CNT_ONE);

    // Stage p0: request to memory.
    always_comb begin
        data_int       = '0;
        data_int.rd_en = vld_p0;
        if (vld_p0) begin
            data_int.addr = cur_addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cur_addr  <= '0;
            len_q     <= '0;
            issue_cnt <= '0;
            acc_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
        end else begin
            done    <= 1'b0;
            vld_p1  <= vld_p0;
            last_p1 <= vld_p0 & last_p0;
            if (pop) begin
                acc_cnt <= acc_cnt + CNT_ONE;
            end
            case (state)
                ST_IDLE: begin
                    if (start && !busy) begin
                        busy <= 1'b1;
                        if (length != '0) begin
                            state     <= ST_RUN;
                            cur_addr  <= base_addr;
                            len_q     <= length;
                            issue_cnt <= '0;
                            acc_cnt   <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end else if (done) begin
                        busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (vld_p0) begin
                        cur_addr  <= next_addr(cur_addr);
                        issue_cnt <= issue_cnt + CNT_ONE;
                        if (last_p0) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (last_beat) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stage p1: read data returns and is pushed with its last tag.
    four_12_12_st1_mem_reader_skid u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (vld_p1),
        .push_data (data_int_rd_data),
        .push_last (last_p1),
        .pop       (pop),
        .head_data (st.out_data),
        .head_last (st.out_last),
        .count     (buf_count)
    );

    assign st.out_valid = (buf_count != 2'd0);

endmodule

// File: tb/tb_four_12_12_st1_mem_reader.sv
// Directed bench for the st1 block reader with a preloaded 32x512 memory model.
module tb_four_12_12_st1_mem_reader;
    import four_12_12_st1_mem_reader_pkg::*;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    data_int_32_9  data_int;
    logic [DW-1:0] rd_data;

    four_12_12_st1_mem_reader_if st_if ();

    four_12_12_st1_mem_reader dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .base_addr        (base_addr),
        .length           (length),
        .busy             (busy),
        .done             (done),
        .data_int         (data_int),
        .data_int_rd_data (rd_data),
        .st               (st_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory_32_9 model: mem[i] = A500_0000 + i, one-cycle read latency
    always @(posedge clk) begin
        if (data_int.rd_en) begin
            rd_data <= 32'hA500_0000 + {23'd0, data_int.addr};
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Stream monitor, sampled mid-cycle
    logic [31:0] beat_data [$];
    logic        beat_last [$];
    logic [8:0]  rd_addr   [$];
    int          done_cnt, rd_cnt, valid_seen, wr_seen, stab_err;
    int          issued, accepted, max_out;
    logic        stall_prev;
    logic [31:0] prev_data;
    logic        prev_last;

    always @(negedge clk) begin
        if (reset) begin
            if (st_if.out_valid) valid_seen++;
            if (st_if.out_valid && st_if.out_ready) begin
                beat_data.push_back(st_if.out_data);
                beat_last.push_back(st_if.out_last);
                accepted++;
            end
            if (done) done_cnt++;
            if (data_int.rd_en) begin
                rd_cnt++;
                issued++;
                rd_addr.push_back(data_int.addr);
            end
            if (data_int.wr_en) wr_seen++;
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (stall_prev && (!st_if.out_valid || st_if.out_data !== prev_data ||
                               st_if.out_last !== prev_last)) stab_err++;
            stall_prev = st_if.out_valid && !st_if.out_ready;
            prev_data  = st_if.out_data;
            prev_last  = st_if.out_last;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic clear_mon();
        beat_data.delete();
        beat_last.delete();
        rd_addr.delete();
        done_cnt = 0; rd_cnt = 0; valid_seen = 0; wr_seen = 0; stab_err = 0;
        issued = 0; accepted = 0; max_out = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input int base, input int i);
        return 32'hA500_0000 + 32'((base + i) % 512);
    endfunction

    // Launch a block and check the whole stream; hold>0 keeps start high with other
    // arguments while busy, which must be ignored.
    task automatic run_block(input string tag, input int base, input int len,
                             input int mode, input int hold);
        int k;
        int d_errs;
        int a_errs;
        int lasts;
        clear_mon();
        base_addr     = base[8:0];
        length        = len[9:0];
        start         = 1'b1;
        st_if.out_ready = 1'b1;
        step();
        for (int h = 0; h < hold; h++) begin
            base_addr = base_addr + 9'd100;
            length    = length + 10'd1;
            step();
        end
        start = 1'b0;
        k = 0;
        while (done_cnt == 0 && k < len * 4 + 40) begin
            st_if.out_ready = (mode == 0) || (k % 3 == 0);
            step();
            k++;
        end
        if (done_cnt == 0) check_val({tag, " timeout"}, 32'd0, 32'd1);
        check_val({tag, " busy after done"}, 32'(busy), 32'd0);
        st_if.out_ready = 1'b1;
        step();
        step();
        check_val({tag, " done pulses"}, 32'(done_cnt), 32'd1);
        check_val({tag, " beats"}, 32'(beat_data.size()), 32'(len));
        d_errs = 0; a_errs = 0; lasts = 0;
        for (int i = 0; i < beat_data.size(); i++) begin
            if (beat_data[i] !== exp_word(base, i)) d_errs++;
            if (beat_last[i]) lasts++;
        end
        for (int i = 0; i < rd_addr.size(); i++) begin
            if (32'(rd_addr[i]) !== 32'((base + i) % 512)) a_errs++;
        end
        check_val({tag, " data errors"}, 32'(d_errs), 32'd0);
        check_val({tag, " reads"}, 32'(rd_cnt), 32'(len));
        check_val({tag, " addr errors"}, 32'(a_errs), 32'd0);
        check_val({tag, " last count"}, 32'(lasts), 32'd1);
        if (beat_last.size() == len) check_val({tag, " last on final"}, 32'(beat_last[len-1]), 32'd1);
        check_val({tag, " stall stability"}, 32'(stab_err), 32'd0);
        check_val({tag, " outstanding<=2"}, 32'(max_out <= 2), 32'd1);
        check_val({tag, " wr_en"}, 32'(wr_seen), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_d;
        reset = 1'b0;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        st_if.out_ready = 1'b1;
        clear_mon();
        step();
        step();
        check_val("rst busy", 32'(busy), 32'd0);
        check_val("rst done", 32'(done), 32'd0);
        check_val("rst out_valid", 32'(st_if.out_valid), 32'd0);
        check_val("rst out_last", 32'(st_if.out_last), 32'd0);
        check_val("rst out_data", st_if.out_data, 32'd0);
        check_val("rst data_int", 32'(data_int), 32'd0);
        reset = 1'b1;
        step();

        // T1: cycle-exact trace, base 0, len 4
        clear_mon();
        base_addr = 9'd0;
        length = 10'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            exp_d = (k >= 3 && k <= 6) ? 32'hA500_0000 + 32'(k - 3) : 32'd0;
            check_val($sformatf("T1 rd_en c%0d", k), 32'(data_int.rd_en), 32'(k >= 1 && k <= 4));
            if (k <= 4) check_val($sformatf("T1 addr c%0d", k), 32'(data_int.addr), 32'(k - 1));
            check_val($sformatf("T1 valid c%0d", k), 32'(st_if.out_valid), 32'(k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) check_val($sformatf("T1 data c%0d", k), st_if.out_data, exp_d);
            check_val($sformatf("T1 last c%0d", k), 32'(st_if.out_valid & st_if.out_last), 32'(k == 6));
            check_val($sformatf("T1 done c%0d", k), 32'(done), 32'(k == 7));
            check_val($sformatf("T1 busy c%0d", k), 32'(busy), 32'(k <= 7));
            step();
        end
        check_val("T1 done pulses", 32'(done_cnt), 32'd1);

        run_block("T2", 510, 4, 0, 0);
        run_block("T3", 20, 8, 1, 0);
        run_block("T4", 0, 512, 0, 0);

        // T5: zero length is a no-op with a done pulse
        clear_mon();
        base_addr = 9'd5;
        length = 10'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("T5 done c1", 32'(done), 32'd1);
        check_val("T5 busy c1", 32'(busy), 32'd1);
        step();
        check_val("T5 done c2", 32'(done), 32'd0);
        check_val("T5 busy c2", 32'(busy), 32'd0);
        step();
        step();
        check_val("T5 reads", 32'(rd_cnt), 32'd0);
        check_val("T5 valid seen", 32'(valid_seen), 32'd0);
        check_val("T5 done pulses", 32'(done_cnt), 32'd1);
        run_block("T5b", 100, 4, 0, 2);

        // T6: reset in the middle of a block
        clear_mon();
        base_addr = 9'd40;
        length = 10'd10;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 50 && beat_data.size() < 3; k++) step();
        check_val("T6 beats before reset", 32'(beat_data.size()), 32'd3);
        reset = 1'b0;
        #1;
        check_val("T6 valid in reset", 32'(st_if.out_valid), 32'd0);
        check_val("T6 data in reset", st_if.out_data, 32'd0);
        check_val("T6 last in reset", 32'(st_if.out_last), 32'd0);
        check_val("T6 busy in reset", 32'(busy), 32'd0);
        check_val("T6 data_int in reset", 32'(data_int), 32'd0);
        step();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) step();
        check_val("T6 no done", 32'(done_cnt), 32'd0);
        check_val("T6 valid after reset", 32'(st_if.out_valid), 32'd0);
        run_block("T6b", 40, 10, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
